// File: rtl/sudoku_cursor_ctrl.sv
// Cursor navigation and digit-entry controller for the 9x9 Sudoku board.
// Turns debounced button pulses into cursor moves, digit edits and board write requests.
module sudoku_cursor_ctrl #(
    parameter int REJECT_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset_fixed,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_ok,
    input  logic       btn_back,
    input  logic       cell_given,
    input  logic       game_done,
    input  logic       wr_ack,
    output logic [3:0] cur_row,
    output logic [3:0] cur_col,
    output logic       edit_mode,
    output logic [3:0] edit_digit,
    output logic       wr_req,
    output logic       btn_block,
    output logic       reject
);

    typedef enum logic [1:0] {
        NAV    = 2'd0,
        EDIT   = 2'd1,
        WRITE  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [24:0] REJECT_LOAD = 25'(REJECT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  row_nxt;
    logic [3:0]  col_nxt;
    logic [3:0]  digit_nxt;
    logic        reject_load;
    logic [24:0] reject_cnt;
    logic [24:0] reject_cnt_nxt;
    logic        edit_mode_nxt;
    logic        wr_req_nxt;
    logic        btn_block_nxt;
    logic        reject_nxt;

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_fixed) begin
        if (!reset_fixed) begin
            state      <= NAV;
            cur_row    <= 4'd0;
            cur_col    <= 4'd0;
            edit_digit <= 4'd0;
            reject_cnt <= 25'd0;
            edit_mode  <= 1'b0;
            wr_req     <= 1'b0;
            btn_block  <= 1'b0;
            reject     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_row    <= row_nxt;
            cur_col    <= col_nxt;
            edit_digit <= digit_nxt;
            reject_cnt <= reject_cnt_nxt;
            edit_mode  <= edit_mode_nxt;
            wr_req     <= wr_req_nxt;
            btn_block  <= btn_block_nxt;
            reject     <= reject_nxt;
        end
    end

    // Only the highest-priority pulse (ok > back > up > down > left > right) is acted on.
    always_comb begin
        state_nxt   = state;
        row_nxt     = cur_row;
        col_nxt     = cur_col;
        digit_nxt   = edit_digit;
        reject_load = 1'b0;
        unique case (state)
            NAV: begin
                if (game_done) begin
                    state_nxt = LOCKED;
                end else if (btn_ok) begin
                    if (cell_given) begin
                        reject_load = 1'b1;
                    end else begin
                        state_nxt = EDIT;
                        digit_nxt = 4'd1;
                    end
                end else if (btn_back) begin
                    state_nxt = NAV;
                end else if (btn_up) begin
                    row_nxt = (cur_row == 4'd0) ? 4'd8 : cur_row - 4'd1;
                end else if (btn_down) begin
                    row_nxt = (cur_row >= 4'd8) ? 4'd0 : cur_row + 4'd1;
                end else if (btn_left) begin
                    col_nxt = (cur_col == 4'd0) ? 4'd8 : cur_col - 4'd1;
                end else if (btn_right) begin
                    col_nxt = (cur_col >= 4'd8) ? 4'd0 : cur_col + 4'd1;
                end
            end
            EDIT: begin
                if (game_done) begin
                    state_nxt = LOCKED;
                    digit_nxt = 4'd0;
                end else if (btn_ok) begin
                    state_nxt = WRITE;
                end else if (btn_back) begin
                    state_nxt = NAV;
                    digit_nxt = 4'd0;
                end else if (btn_up) begin
                    digit_nxt = (edit_digit >= 4'd9) ? 4'd0 : edit_digit + 4'd1;
                end else if (btn_down) begin
                    digit_nxt = (edit_digit == 4'd0) ? 4'd9 : edit_digit - 4'd1;
                end
            end
            WRITE: begin
                if (wr_ack) begin
                    state_nxt = game_done ? LOCKED : NAV;
                    digit_nxt = 4'd0;
                end
            end
            LOCKED: begin
                state_nxt = LOCKED;
            end
            default: begin
                state_nxt = NAV;
            end
        endcase
    end

    // Output values for the next cycle follow the next state so they stay registered.
    always_comb begin
        edit_mode_nxt  = (state_nxt == EDIT);
        wr_req_nxt     = (state_nxt == WRITE);
        btn_block_nxt  = (state_nxt == WRITE) || (state_nxt == LOCKED);
        reject_cnt_nxt = reject_cnt;
        if (reject_load) begin
            reject_cnt_nxt = REJECT_LOAD;
        end else if (reject_cnt != 25'd0) begin
            reject_cnt_nxt = reject_cnt - 25'd1;
        end
        reject_nxt = (reject_cnt_nxt != 25'd0);
    end

endmodule

// File: tb/tb_sudoku_cursor_ctrl.sv
// Directed self-checking bench for sudoku_cursor_ctrl with a short reject flash.
module tb_sudoku_cursor_ctrl;

    localparam int REJ = 10;

    // Button vector order: {ok, back, up, down, left, right}
    localparam logic [5:0] B_NONE  = 6'b000000;
    localparam logic [5:0] B_OK    = 6'b100000;
    localparam logic [5:0] B_BACK  = 6'b010000;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DOWN  = 6'b000100;
    localparam logic [5:0] B_LEFT  = 6'b000010;
    localparam logic [5:0] B_RIGHT = 6'b000001;

    logic       clk;
    logic       reset_fixed;
    logic       btn_up, btn_down, btn_left, btn_right, btn_ok, btn_back;
    logic       cell_given, game_done, wr_ack;
    logic [3:0] cur_row, cur_col, edit_digit;
    logic       edit_mode, wr_req, btn_block, reject;

    int checks   = 0;
    int failures = 0;
    logic wr_seen;

    sudoku_cursor_ctrl #(.REJECT_CYCLES(REJ)) dut (
        .clk        (clk),
        .reset_fixed(reset_fixed),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_ok     (btn_ok),
        .btn_back   (btn_back),
        .cell_given (cell_given),
        .game_done  (game_done),
        .wr_ack     (wr_ack),
        .cur_row    (cur_row),
        .cur_col    (cur_col),
        .edit_mode  (edit_mode),
        .edit_digit (edit_digit),
        .wr_req     (wr_req),
        .btn_block  (btn_block),
        .reject     (reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (wr_req === 1'b1) wr_seen = 1'b1;

    // Drive one cycle of buttons, let one edge sample them, then release.
    task automatic apply_stimulus(input logic [5:0] b);
        {btn_ok, btn_back, btn_up, btn_down, btn_left, btn_right} = b;
        @(posedge clk);
        #1;
        {btn_ok, btn_back, btn_up, btn_down, btn_left, btn_right} = B_NONE;
    endtask

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        reset_fixed = 1'b0;
        #12;
        @(posedge clk);
        #1;
        reset_fixed = 1'b1;
    endtask

    initial begin
        reset_fixed = 1'b0;
        {btn_ok, btn_back, btn_up, btn_down, btn_left, btn_right} = B_NONE;
        cell_given = 1'b0;
        game_done  = 1'b0;
        wr_ack     = 1'b0;
        wr_seen    = 1'b0;

        do_reset();
        check_output("rst_row", cur_row, 0);
        check_output("rst_col", cur_col, 0);
        check_output("rst_edit_mode", edit_mode, 0);
        check_output("rst_digit", edit_digit, 0);
        check_output("rst_wr_req", wr_req, 0);
        check_output("rst_block", btn_block, 0);
        check_output("rst_reject", reject, 0);

        // Column walk wraps 8 -> 0 without touching the row
        for (int i = 1; i <= 9; i++) begin
            apply_stimulus(B_RIGHT);
            check_output("walk_col", cur_col, i % 9);
            check_output("walk_row", cur_row, 0);
        end
        apply_stimulus(B_UP);
        check_output("up_wrap_row", cur_row, 8);

        // Move to (2,3)
        repeat (3) apply_stimulus(B_DOWN);
        repeat (3) apply_stimulus(B_RIGHT);
        check_output("pos_row", cur_row, 2);
        check_output("pos_col", cur_col, 3);

        wr_seen = 1'b0;
        apply_stimulus(B_OK);
        check_output("edit_enter_mode", edit_mode, 1);
        check_output("edit_enter_digit", edit_digit, 1);
        apply_stimulus(B_DOWN);
        check_output("digit_down0", edit_digit, 0);
        apply_stimulus(B_DOWN);
        check_output("digit_down9", edit_digit, 9);
        apply_stimulus(B_UP);
        check_output("digit_up_wrap", edit_digit, 0);
        apply_stimulus(B_LEFT);
        check_output("edit_left_ignored", cur_col, 3);
        apply_stimulus(B_BACK);
        check_output("back_mode", edit_mode, 0);
        check_output("back_digit", edit_digit, 0);
        check_output("back_no_write", wr_seen, 0);

        // Write handshake with digit 5
        apply_stimulus(B_OK);
        repeat (4) apply_stimulus(B_UP);
        check_output("digit5", edit_digit, 5);
        apply_stimulus(B_OK);
        check_output("write_req", wr_req, 1);
        check_output("write_block", btn_block, 1);
        check_output("write_mode", edit_mode, 0);
        apply_stimulus(B_UP);
        check_output("write_up_ignored", edit_digit, 5);
        apply_stimulus(B_LEFT);
        check_output("write_left_ignored", cur_col, 3);
        apply_stimulus(B_NONE);
        check_output("write_held", wr_req, 1);
        wr_ack = 1'b1;
        apply_stimulus(B_NONE);
        wr_ack = 1'b0;
        check_output("ack_req", wr_req, 0);
        check_output("ack_block", btn_block, 0);
        check_output("ack_digit", edit_digit, 0);
        check_output("ack_row", cur_row, 2);
        check_output("ack_col", cur_col, 3);
        apply_stimulus(B_RIGHT);
        check_output("after_ack_nav", cur_col, 4);
        apply_stimulus(B_LEFT);

        // Stray ack outside WRITE
        wr_ack = 1'b1;
        apply_stimulus(B_NONE);
        wr_ack = 1'b0;
        check_output("stray_ack_block", btn_block, 0);
        check_output("stray_ack_req", wr_req, 0);

        // Reject flash with a reload at cycle 6
        cell_given = 1'b1;
        apply_stimulus(B_OK);
        check_output("rej_start", reject, 1);
        check_output("rej_stay_nav", edit_mode, 0);
        for (int i = 2; i <= 5; i++) begin
            apply_stimulus(B_NONE);
            check_output("rej_first_flash", reject, 1);
        end
        apply_stimulus(B_OK);
        check_output("rej_reload", reject, 1);
        cell_given = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            apply_stimulus(B_NONE);
            check_output("rej_hold", reject, 1);
        end
        apply_stimulus(B_NONE);
        check_output("rej_end", reject, 0);

        // ok wins over right
        apply_stimulus(B_OK | B_RIGHT);
        check_output("prio_mode", edit_mode, 1);
        check_output("prio_col", cur_col, 3);

        // game_done during WRITE waits for the ack, then locks
        apply_stimulus(B_UP);
        apply_stimulus(B_OK);
        game_done = 1'b1;
        apply_stimulus(B_NONE);
        apply_stimulus(B_NONE);
        check_output("done_write_held", wr_req, 1);
        wr_ack = 1'b1;
        apply_stimulus(B_NONE);
        wr_ack = 1'b0;
        check_output("lock_req", wr_req, 0);
        check_output("lock_block", btn_block, 1);
        check_output("lock_digit", edit_digit, 0);
        game_done = 1'b0;
        apply_stimulus(B_RIGHT);
        check_output("lock_col_frozen", cur_col, 3);
        apply_stimulus(B_OK);
        check_output("lock_ok_ignored", edit_mode, 0);
        check_output("lock_block_held", btn_block, 1);

        // game_done in EDIT discards the digit and locks
        do_reset();
        apply_stimulus(B_OK);
        apply_stimulus(B_UP);
        check_output("edit_digit2", edit_digit, 2);
        game_done = 1'b1;
        apply_stimulus(B_NONE);
        game_done = 1'b0;
        check_output("edit_lock_mode", edit_mode, 0);
        check_output("edit_lock_digit", edit_digit, 0);
        check_output("edit_lock_block", btn_block, 1);

        // Asynchronous reset in the middle of a write
        do_reset();
        apply_stimulus(B_DOWN);
        apply_stimulus(B_OK);
        apply_stimulus(B_OK);
        check_output("pre_rst_req", wr_req, 1);
        #2;
        reset_fixed = 1'b0;
        #1;
        check_output("async_req", wr_req, 0);
        check_output("async_block", btn_block, 0);
        check_output("async_row", cur_row, 0);
        check_output("async_digit", edit_digit, 0);
        check_output("async_mode", edit_mode, 0);
        #20;
        reset_fixed = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sudoku_cursor_ctrl.md
# sudoku_cursor_ctrl

Navigation and entry controller for the Sudoku board. It consumes the single-cycle pulses from the six button debouncers and moves a cursor over the 9×9 grid. It runs a digit-edit mode and issues write requests to the board storage. It drives the debouncers' `block` input while a write is in flight or the game is over.

## Interface
Parameters:
- `REJECT_CYCLES`, 25_000_000: length of the `reject` flash in clk cycles (0.5 s @ 50 MHz); legal range 1 to 2^25−1.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `reset_fixed`  in  1  asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_ok`, `btn_back`  in  1 each  one-cycle debounced pulses, active-high.
- `cell_given`  in  1  board flag: the cell at (`cur_row`,`cur_col`) is a fixed clue; valid combinationally for the current cursor.
- `game_done`  in  1  level, board solved.
- `wr_ack`  in  1  board accepted the write; one-cycle pulse.
- `cur_row`, `cur_col`  out  4 each  cursor position, 0–8.
- `edit_mode`  out  1  high in EDIT.
- `edit_digit`  out  4  candidate digit, 0–9; 0 = erase.
- `wr_req`  out  1  write request; row/col/digit are taken from `cur_row`/`cur_col`/`edit_digit`.
- `btn_block`  out  1  to all debouncers' `block` input.
- `reject`  out  1  flash indicating an attempt to edit a given cell.

## Operation
- States: NAV, EDIT, WRITE, LOCKED. Reset enters NAV.
- Button priority when several pulses arrive in one cycle: ok > back > up > down > left > right. Exactly one pulse is acted on; the others are dropped.
- NAV:
  - Up/down change `cur_row` by −1/+1; left/right change `cur_col` by −1/+1. Each is mod 9 (0−1→8, 8+1→0). A column wrap does not change the row.
  - Ok with `cell_given`=0: go to EDIT and set `edit_digit`=1.
  - Ok with `cell_given`=1: stay in NAV and start the reject flash.
  - Back: no effect.
- EDIT:
  - Up increments `edit_digit` mod 10 (9→0). Down decrements it (0→9).
  - Left/right are ignored.
  - Ok: go to WRITE.
  - Back: go to NAV; `edit_digit`←0 and no write occurs.
- WRITE:
  - `wr_req`=1; cursor and `edit_digit` are held stable. All buttons are ignored.
  - `wr_ack` clears `wr_req` and sets `edit_digit`←0. Next state is LOCKED if `game_done`=1 in that cycle, otherwise NAV.
  - No timeout; only reset escapes a missing ack.
- LOCKED:
  - Terminal state; only `reset_fixed` exits it.
  - Cursor is frozen and buttons are ignored.
- `game_done`=1 in NAV or EDIT moves to LOCKED on the next edge. In EDIT the pending digit is discarded (`edit_digit`←0). In WRITE the handshake completes first.
- `btn_block`=1 in WRITE and LOCKED, 0 otherwise.
- `edit_mode`=1 only in EDIT.
- Reject counter (25 bit):
  - A reject loads REJECT_CYCLES; `reject`=(counter≠0); the counter decrements to 0.
  - A new reject while the flash is active reloads the counter.
  - The counter runs independently of state, including after entering LOCKED.
- `wr_ack` while `wr_req`=0 is ignored.

## Timing
- All outputs are registered. Reset values: `cur_row`=0, `cur_col`=0, `edit_mode`=0, `edit_digit`=0, `wr_req`=0, `btn_block`=0, `reject`=0, reject counter=0.
- Latency from an input sampled at edge k to its effect on outputs: 1 edge (visible after edge k).
- `wr_req` rises at the edge that samples ok in EDIT. `btn_block` rises at the same edge.
- `wr_ack` sampled at edge k: `wr_req` and `btn_block` are 0 after edge k and the state is NAV or LOCKED. Minimum `wr_req` width is 1 cycle; an ack in the first request cycle is legal.
- `reject` is high for exactly REJECT_CYCLES cycles, starting the edge after the ok pulse.
- `cell_given` is sampled at the ok edge only.
- `reset_fixed` low forces all reset values immediately, including mid-WRITE (`wr_req` drops without an ack).

## Test plan
- Reset, then 9 × `btn_right` pulses → `cur_col` goes 1…8 then 0 and `cur_row` stays 0. Then 1 × `btn_up` → `cur_row`=8.
- Cursor (2,3), `cell_given`=0, ok → `edit_mode`=1, `edit_digit`=1. Then down ×2 → 9. Then up → 0. Then back → NAV, `edit_digit`=0, and `wr_req` never asserts.
- EDIT with digit 5, ok → `wr_req`=1 and `btn_block`=1; up/left pulses are ignored. `wr_ack` after 4 cycles → `wr_req`=0, state NAV, cursor unchanged.
- REJECT_CYCLES=10, `cell_given`=1, ok → `reject` high for 10 cycles and state stays NAV. A second ok at cycle 6 → `reject` is high for 10 cycles from that point.
- `btn_ok` and `btn_right` in the same cycle in NAV → EDIT entered and `cur_col` unchanged.
- `game_done`=1 during WRITE → stays in WRITE until `wr_ack`, then LOCKED with `btn_block`=1 and buttons ignored. Assert `reset_fixed`=0 mid-WRITE → all outputs return to reset values asynchronously.
